// File: rtl/jtag_master.sv
// Host-side JTAG initiator: turns reset/IR/DR/idle commands into TCK/TMS/TDI
// waveforms and returns the captured TDO bits on a response channel.
module jtag_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtag_TCK,
  output logic               jtag_TMS,
  output logic               jtag_TDI,
  input  logic               jtag_TDO,
  output logic [1:0]         dbg_state
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  typedef struct packed {
    logic          shift;
    logic          tms;
    logic          tdi;
    logic [IW-1:0] idx;
  } seq_t;

  // Handshakes: a transfer happens on any clk edge where valid && ready are both
  // high. cmd_ready is high only in IDLE; rsp_valid/rsp_data hold until rsp_ready.

  function automatic logic [7:0] f_eff_len(input logic [1:0] typ, input logic [6:0] len);
    logic [7:0] l;
    l = {1'b0, len};
    if (typ == 2'd1 || typ == 2'd2) begin
      if (l == 8'd0) l = 8'd1;
      else if (l > LEN_MAX) l = LEN_MAX;
    end
    return l;
  endfunction

  function automatic logic [7:0] f_total(input logic [1:0] typ, input logic [7:0] len);
    case (typ)
      2'd0:    return 8'd6;
      2'd1:    return len + 8'd6;
      2'd2:    return len + 8'd5;
      default: return len;
    endcase
  endfunction

  // TMS/TDI and shift position for rising edge e of a command, starting and
  // ending in Run-Test/Idle.
  function automatic seq_t f_seq(input logic [1:0] typ, input logic [7:0] len,
                                 input logic [7:0] e, input logic [MAX_LEN-1:0] data);
    seq_t       s;
    logic [7:0] pre;
    logic [7:0] rel;
    s   = '0;
    pre = (typ == 2'd1) ? 8'd4 : 8'd3;
    rel = e - pre;
    case (typ)
      2'd0: s.tms = (e < 8'd5);
      2'd1, 2'd2: begin
        if (e < pre) begin
          s.tms = (typ == 2'd1) ? (e < 8'd2) : (e == 8'd0);
        end else if (rel < len) begin
          s.shift = 1'b1;
          s.idx   = rel[IW-1:0];
          s.tdi   = data[rel[IW-1:0]];
          s.tms   = (rel == len - 8'd1);
        end else begin
          s.tms = (rel == len);
        end
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  state_t               r_state;
  state_t               w_next;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic                 r_tck;
  logic                 r_tms;
  logic                 r_tdi;
  logic [DW-1:0]        r_div;
  logic [7:0]           r_edge;
  logic [7:0]           r_total;
  logic [1:0]           r_type;
  logic [7:0]           r_len;
  logic [MAX_LEN-1:0]   r_data;
  logic [MAX_LEN-1:0]   r_rsp;

  logic                 w_accept;
  logic                 w_tick;
  logic                 w_last;
  logic [7:0]           w_cmd_len;
  logic [1:0]           w_seq_typ;
  logic [7:0]           w_seq_len;
  logic [7:0]           w_seq_edge;
  logic [MAX_LEN-1:0]   w_seq_data;
  seq_t                 w_seq;

  assign w_accept  = cmd_valid && r_cmd_ready && (r_state == S_IDLE);
  assign w_tick    = (r_div == DIV_LAST);
  assign w_last    = (r_edge == r_total - 8'd1);
  assign w_cmd_len = f_eff_len(cmd_type, cmd_len);

  // One sequence decoder: in IDLE it looks at the incoming command (first bit),
  // while running it looks at the current edge before a rise and the next edge
  // before a fall.
  assign w_seq_typ  = (r_state == S_IDLE) ? cmd_type  : r_type;
  assign w_seq_len  = (r_state == S_IDLE) ? w_cmd_len : r_len;
  assign w_seq_data = (r_state == S_IDLE) ? cmd_data  : r_data;
  assign w_seq_edge = (r_state == S_IDLE) ? 8'd0 : (r_tck ? r_edge + 8'd1 : r_edge);
  assign w_seq      = f_seq(w_seq_typ, w_seq_len, w_seq_edge, w_seq_data);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (cmd_type == 2'd3 && cmd_len == 7'd0) ? S_RSP : S_RUN;
      S_RUN:  if (w_tick && r_tck && w_last) w_next = S_RSP;
      S_RSP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_div       <= '0;
      r_edge      <= 8'd0;
      r_total     <= 8'd0;
      r_type      <= 2'd0;
      r_len       <= 8'd0;
      r_data      <= '0;
      r_rsp       <= '0;
    end else begin
      r_cmd_ready <= (w_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_type  <= cmd_type;
            r_len   <= w_cmd_len;
            r_data  <= cmd_data;
            r_total <= f_total(cmd_type, w_cmd_len);
            r_edge  <= 8'd0;
            r_div   <= '0;
            r_tck   <= 1'b0;
            r_rsp   <= '0;
            r_tms   <= w_seq.tms;
            r_tdi   <= w_seq.tdi;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            r_div <= '0;
            r_tck <= ~r_tck;
            if (!r_tck) begin
              if (w_seq.shift) r_rsp[w_seq.idx] <= jtag_TDO;
            end else begin
              r_edge <= r_edge + 8'd1;
              // Final fall parks the pins at TMS=0/TDI=0 so the TAP idles.
              if (w_last) begin
                r_tms <= 1'b0;
                r_tdi <= 1'b0;
              end else begin
                r_tms <= w_seq.tms;
                r_tdi <= w_seq.tdi;
              end
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_RSP: begin
          r_tck <= 1'b0;
          if (rsp_ready) r_busy <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_data  = r_rsp;
  assign busy      = r_busy;
  assign jtag_TCK  = r_tck;
  assign jtag_TMS  = r_tms;
  assign jtag_TDI  = r_tdi;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master: pin monitor plus an independent 16-state TAP
// model that returns a fixed IDCODE from its data register.
module tb_jtag_master;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 64;
  localparam logic [31:0] IDCODE = 32'h1E200A6D;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = 2'd0;
  logic [6:0]         cmd_len = 7'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               jtag_TCK;
  logic               jtag_TMS;
  logic               jtag_TDI;
  logic               jtag_TDO;
  logic [1:0]         dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI),
    .jtag_TDO(jtag_TDO), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // pin monitor: one record per rising TCK
  logic tms_q[$];
  logic tdi_q[$];
  int   rise_q[$];
  always @(posedge jtag_TCK) begin
    tms_q.push_back(jtag_TMS);
    tdi_q.push_back(jtag_TDI);
    rise_q.push_back(cyc);
  end

  // TAP target model
  int          tap_st = 0;
  logic [31:0] tap_sr = '0;
  logic        tap_tdo = 1'b0;
  int          tdo_mode = 0;

  function automatic int tap_next(input int s, input logic tms);
    case (s)
      0:  return tms ? 0  : 1;
      1:  return tms ? 2  : 1;
      2:  return tms ? 9  : 3;
      3:  return tms ? 5  : 4;
      4:  return tms ? 5  : 4;
      5:  return tms ? 8  : 6;
      6:  return tms ? 7  : 6;
      7:  return tms ? 8  : 4;
      8:  return tms ? 2  : 1;
      9:  return tms ? 0  : 10;
      10: return tms ? 12 : 11;
      11: return tms ? 12 : 11;
      12: return tms ? 15 : 13;
      13: return tms ? 14 : 13;
      14: return tms ? 15 : 11;
      15: return tms ? 2  : 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge jtag_TCK) begin
    if (tap_st == 3)      tap_sr = IDCODE;
    else if (tap_st == 4) tap_sr = {jtag_TDI, tap_sr[31:1]};
    tap_st = tap_next(tap_st, jtag_TMS);
  end
  always @(negedge jtag_TCK) tap_tdo = tap_sr[0];

  assign jtag_TDO = (tdo_mode == 0) ? 1'b0 : (tdo_mode == 1) ? 1'b1 : tap_tdo;

  function automatic logic [127:0] pack_tms();
    logic [127:0] v = '0;
    foreach (tms_q[i]) if (i < 128) v[i] = tms_q[i];
    return v;
  endfunction

  function automatic logic [127:0] pack_tdi();
    logic [127:0] v = '0;
    foreach (tdi_q[i]) if (i < 128) v[i] = tdi_q[i];
    return v;
  endfunction

  function automatic logic spacing_ok();
    logic ok = 1'b1;
    for (int i = 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] != 2 * CLK_DIV) ok = 1'b0;
    return ok;
  endfunction

  // driver tasks
  task automatic clear_mon();
    tms_q.delete();
    tdi_q.delete();
    rise_q.delete();
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [6:0] l,
                          input logic [63:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_ready_wait got %b exp 1", cmd_ready);
    end
    cmd_type  = t;
    cmd_len   = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc       = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [63:0] d, output int lat);
    int n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rsp_wait got %b exp 1", rsp_valid);
    end
    d = rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({jtag_TCK, jtag_TMS, jtag_TDI} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_pins got %b exp 010", {jtag_TCK, jtag_TMS, jtag_TDI});
    end
    n_vec++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_handshake got %b exp 000", {cmd_ready, rsp_valid, busy});
    end
    n_vec++;
    if (rsp_data !== 64'h0) begin
      n_err++;
      $display("FAIL reset_rsp_data got %h exp 0", rsp_data);
    end
    n_vec++;
    if (dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got %0d exp 0", dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_rise got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_tap_reset();
    int acc, lat;
    logic [63:0] d;
    clear_mon();
    tdo_mode = 0;
    send_cmd(2'd0, 7'd0, 64'h0, acc);
    wait_rsp(d, lat);
    n_vec++;
    if (tms_q.size() != 6) begin
      n_err++;
      $display("FAIL tapreset_rises got %0d exp 6", tms_q.size());
    end
    n_vec++;
    if (pack_tms() !== 128'h1F) begin
      n_err++;
      $display("FAIL tapreset_tms got %h exp 1f", pack_tms());
    end
    n_vec++;
    if (rise_q.size() == 0 || rise_q[0] != acc + CLK_DIV) begin
      n_err++;
      $display("FAIL tapreset_first_rise got %0d exp %0d", rise_q.size() ? rise_q[0] : -1, acc + CLK_DIV);
    end
    n_vec++;
    if (spacing_ok() !== 1'b1) begin
      n_err++;
      $display("FAIL tapreset_spacing got uneven exp %0d", 2 * CLK_DIV);
    end
    n_vec++;
    if (d !== 64'h0) begin
      n_err++;
      $display("FAIL tapreset_rsp got %h exp 0", d);
    end
    n_vec++;
    if ({jtag_TCK, jtag_TMS, busy, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL tapreset_after got %b exp 0001", {jtag_TCK, jtag_TMS, busy, cmd_ready});
    end
    n_vec++;
    if (tap_st != 1) begin
      n_err++;
      $display("FAIL tapreset_tap_state got %0d exp 1", tap_st);
    end
  endtask

  task automatic test_shift_ir();
    int acc, lat;
    logic [63:0] d;
    clear_mon();
    tdo_mode = 0;
    send_cmd(2'd1, 7'd5, 64'h01, acc);
    wait_rsp(d, lat);
    n_vec++;
    if (tms_q.size() != 11) begin
      n_err++;
      $display("FAIL ir_rises got %0d exp 11", tms_q.size());
    end
    n_vec++;
    if (pack_tms() !== 128'h303) begin
      n_err++;
      $display("FAIL ir_tms got %h exp 303", pack_tms());
    end
    n_vec++;
    if (pack_tdi() !== 128'h10) begin
      n_err++;
      $display("FAIL ir_tdi got %h exp 10", pack_tdi());
    end
    n_vec++;
    if (d !== 64'h0) begin
      n_err++;
      $display("FAIL ir_rsp got %h exp 0", d);
    end
    n_vec++;
    if (tap_st != 1) begin
      n_err++;
      $display("FAIL ir_tap_state got %0d exp 1", tap_st);
    end
  endtask

  task automatic test_shift_dr();
    int acc, lat;
    logic [63:0] d;
    clear_mon();
    tdo_mode = 1;
    send_cmd(2'd2, 7'd32, 64'hDEADBEEF, acc);
    wait_rsp(d, lat);
    n_vec++;
    if (tms_q.size() != 37) begin
      n_err++;
      $display("FAIL dr_rises got %0d exp 37", tms_q.size());
    end
    n_vec++;
    if (pack_tms() !== 128'h0000000C00000001) begin
      n_err++;
      $display("FAIL dr_tms got %h exp c00000001", pack_tms());
    end
    n_vec++;
    if (pack_tdi() !== (128'hDEADBEEF << 3)) begin
      n_err++;
      $display("FAIL dr_tdi got %h exp %h", pack_tdi(), 128'hDEADBEEF << 3);
    end
    n_vec++;
    if (d !== 64'h00000000FFFFFFFF) begin
      n_err++;
      $display("FAIL dr_rsp_ones got %h exp 00000000ffffffff", d);
    end
    clear_mon();
    tdo_mode = 2;
    send_cmd(2'd2, 7'd32, 64'h0, acc);
    wait_rsp(d, lat);
    tdo_mode = 0;
    n_vec++;
    if (d !== {32'h0, IDCODE}) begin
      n_err++;
      $display("FAIL dr_idcode got %h exp %h", d, IDCODE);
    end
    n_vec++;
    if (tap_st != 1) begin
      n_err++;
      $display("FAIL dr_tap_state got %0d exp 1", tap_st);
    end
  endtask

  task automatic test_len_rules();
    int acc, lat;
    logic [63:0] d;
    clear_mon();
    tdo_mode = 1;
    send_cmd(2'd2, 7'd0, 64'h1, acc);
    wait_rsp(d, lat);
    n_vec++;
    if (tms_q.size() != 6 || pack_tms() !== 128'h19) begin
      n_err++;
      $display("FAIL len0_tms got %0d/%h exp 6/19", tms_q.size(), pack_tms());
    end
    n_vec++;
    if (pack_tdi() !== 128'h8 || d !== 64'h1) begin
      n_err++;
      $display("FAIL len0_data got tdi %h rsp %h exp 8 1", pack_tdi(), d);
    end
    clear_mon();
    send_cmd(2'd1, 7'd100, {64{1'b1}}, acc);
    wait_rsp(d, lat);
    n_vec++;
    if (tms_q.size() != 70) begin
      n_err++;
      $display("FAIL clamp_rises got %0d exp 70", tms_q.size());
    end
    n_vec++;
    if (pack_tms() !== 128'h00000000_00000018_00000000_00000003) begin
      n_err++;
      $display("FAIL clamp_tms got %h exp 18_0000000000000003", pack_tms());
    end
    n_vec++;
    if (d !== {64{1'b1}}) begin
      n_err++;
      $display("FAIL clamp_rsp got %h exp ffffffffffffffff", d);
    end
    tdo_mode = 0;
  endtask

  task automatic test_backpressure();
    int acc, n;
    logic ok_v, ok_d, ok_r, ok_b, ok_t, ok_s;
    clear_mon();
    tdo_mode = 1;
    send_cmd(2'd2, 7'd8, 64'hA5, acc);
    n = 0;
    while (!rsp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    {ok_v, ok_d, ok_r, ok_b, ok_t, ok_s} = 6'b111111;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        cmd_type  = 2'd0;
        cmd_valid = 1'b1;
      end
      if (rsp_valid !== 1'b1) ok_v = 1'b0;
      if (rsp_data !== 64'hFF) ok_d = 1'b0;
      if (cmd_ready !== 1'b0) ok_r = 1'b0;
      if (busy !== 1'b1) ok_b = 1'b0;
      if (jtag_TCK !== 1'b0) ok_t = 1'b0;
      if (dbg_state !== 2'd2) ok_s = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (!ok_v) begin n_err++; $display("FAIL stall_valid got dropped exp held 1"); end
    n_vec++;
    if (!ok_d) begin n_err++; $display("FAIL stall_data got %h exp ff", rsp_data); end
    n_vec++;
    if (!ok_r) begin n_err++; $display("FAIL stall_cmd_ready got 1 exp 0"); end
    n_vec++;
    if (!ok_b) begin n_err++; $display("FAIL stall_busy got 0 exp 1"); end
    n_vec++;
    if (!ok_t) begin n_err++; $display("FAIL stall_tck got 1 exp 0"); end
    n_vec++;
    if (!ok_s) begin n_err++; $display("FAIL stall_state got %0d exp 2", dbg_state); end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL handshake_busy_before got %b exp 1", busy);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    n_vec++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL handshake_after got %b exp 00", {busy, rsp_valid});
    end
    for (int i = 0; i < 10; i++) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || tms_q.size() != 13) begin
      n_err++;
      $display("FAIL ignored_cmd got busy %b rises %0d exp 0 13", busy, tms_q.size());
    end
    tdo_mode = 0;
  endtask

  task automatic test_abort();
    int acc, n;
    logic seen_rsp;
    clear_mon();
    send_cmd(2'd2, 7'd16, 64'h1234, acc);
    n = 0;
    while (tms_q.size() < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({jtag_TCK, jtag_TMS, busy, rsp_valid, cmd_ready} !== 5'b01000) begin
      n_err++;
      $display("FAIL abort_outputs got %b exp 01000", {jtag_TCK, jtag_TMS, busy, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_ready got %b exp 1", cmd_ready);
    end
    seen_rsp = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) seen_rsp = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (seen_rsp !== 1'b0 || tms_q.size() != 10) begin
      n_err++;
      $display("FAIL abort_quiet got rsp %b rises %0d exp 0 10", seen_rsp, tms_q.size());
    end
  endtask

  task automatic test_idle();
    int acc, lat;
    logic [63:0] d;
    clear_mon();
    send_cmd(2'd0, 7'd0, 64'h0, acc);
    wait_rsp(d, lat);
    n_vec++;
    if (tap_st != 1) begin
      n_err++;
      $display("FAIL rereset_tap_state got %0d exp 1", tap_st);
    end
    clear_mon();
    send_cmd(2'd3, 7'd0, 64'hFFFF, acc);
    wait_rsp(d, lat);
    n_vec++;
    if (lat > 1 || tms_q.size() != 0 || d !== 64'h0) begin
      n_err++;
      $display("FAIL idle0 got lat %0d rises %0d rsp %h exp <=1 0 0", lat, tms_q.size(), d);
    end
    clear_mon();
    send_cmd(2'd3, 7'd3, 64'hFFFF, acc);
    wait_rsp(d, lat);
    n_vec++;
    if (tms_q.size() != 3) begin
      n_err++;
      $display("FAIL idle3_rises got %0d exp 3", tms_q.size());
    end
    n_vec++;
    if (pack_tms() !== 128'h0 || pack_tdi() !== 128'h0 || d !== 64'h0) begin
      n_err++;
      $display("FAIL idle3_pins got tms %h tdi %h rsp %h exp 0 0 0", pack_tms(), pack_tdi(), d);
    end
    n_vec++;
    if (tap_st != 1) begin
      n_err++;
      $display("FAIL idle3_tap_state got %0d exp 1", tap_st);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tap_reset();
    test_shift_ir();
    test_shift_dr();
    test_len_rules();
    test_backpressure();
    test_abort();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG driver: the initiator end of the SoC's jtag_pin_TCK/TMS/TDI/TDO debug port.
- Accepts commands on a valid/ready interface: TAP reset, IR shift, DR shift, idle clocks.
- Generates the TCK/TMS/TDI waveforms, captures TDO, and returns the captured bits on a valid/ready response channel.
- Used by the system bench and the debug loader to reach the core's debug TAP.

Parameters:
CLK_DIV, 4, clk cycles per TCK half-period (legal range >= 1)
MAX_LEN, 64, maximum shift length in bits; width of cmd_data and rsp_data

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block accepts a command this cycle
cmd_type  input  2  0=TAP reset, 1=shift IR, 2=shift DR, 3=idle
cmd_len  input  7  shift length in bits (types 1/2), or TCK count (type 3)
cmd_data  input  MAX_LEN  TDI bits, LSB shifted first
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed
rsp_data  output  MAX_LEN  captured TDO bits
busy  output  1  high from command accept until response handshake
jtag_TCK  output  1  JTAG clock
jtag_TMS  output  1  JTAG mode select
jtag_TDI  output  1  JTAG data to target
jtag_TDO  input  1  JTAG data from target

Behaviour:
- Reset values (one clk after rst sampled high):
  - jtag_TCK=0, jtag_TMS=1, jtag_TDI=0.
  - cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - Divider and bit counter = 0; FSM = IDLE.
  - cmd_ready rises on the following cycle.
- A command is accepted when cmd_valid && cmd_ready. cmd_ready is high only in IDLE.
- The accept cycle latches cmd_type, cmd_len and cmd_data, and sets busy=1.
- TCK:
  - Toggles every CLK_DIV clk cycles while a command runs; period is 2*CLK_DIV clk cycles.
  - Held low in IDLE and RSP.
  - The first TCK rise occurs CLK_DIV cycles after accept.
- TMS/TDI change only in the clk cycle where TCK falls (or at accept for the first bit).
- TDO is sampled in the clk cycle where TCK rises.
- Host TAP state is Run-Test/Idle between commands, except after reset, where the TAP state is undefined until a type-0 command runs.
- TMS bit sequence per rising TCK edge:
  - type 0: 1,1,1,1,1,0 (6 edges).
  - type 1: 1,1,0,0, then len shift edges with TMS=0 except the last, which is TMS=1, then 1,0. Total len+6 edges.
  - type 2: 1,0,0, then len shift edges as for type 1, then 1,0. Total len+5 edges.
  - type 3: len edges, all TMS=0, TDI=0.
- Shift data:
  - During shift edge i (0-based), TDI=cmd_data[i].
  - TDO sampled at that edge goes to rsp_data[i]; bits >= len read 0.
  - Outside shift edges, TDI=0.
- Length rules:
  - Types 1/2: len=0 is treated as len=1; len>MAX_LEN is clamped to MAX_LEN.
  - Type 3: len=0 generates no TCK edges and goes straight to RSP.
- FSM states:
  - IDLE -accept-> RUN.
  - RUN: edge counter steps through the sequence above; -last falling edge done-> RSP.
  - RSP: rsp_valid=1; -rsp_ready-> IDLE.
  - The last falling edge leaves TCK=0 and TMS=0.
- Response rules:
  - Every command produces exactly one response; rsp_data=0 for types 0 and 3.
  - rsp_valid and rsp_data are held stable until rsp_ready. No new command is accepted meanwhile.
  - TCK stays low while stalled.
- busy falls in the cycle after the response handshake.
- rst asserted mid-command aborts it immediately:
  - Outputs return to reset values on the next clk.
  - No response is issued.
  - The TAP must then be re-reset with a type-0 command.
- cmd_valid asserted while not ready is ignored; it must not be latched.

Test Plan:
- CLK_DIV=2, TAP reset command → 6 TCK rises, 4 clk apart; TMS at rises = 1,1,1,1,1,0; rsp_valid with rsp_data=0; TCK=0 afterwards.
- Shift IR, len=5, data=0x01, TDO tied 0 → 11 TCK rises; TMS = 1,1,0,0,0,0,0,0,1,1,0; TDI at shift edges = 1,0,0,0,0; rsp_data=0.
- Shift DR, len=32, data=0xDEADBEEF, TDO tied 1 → 37 rises; TDI bits are 0xDEADBEEF LSB first; rsp_data=0x00000000FFFFFFFF. Repeat with a bench 32-bit TAP model returning IDCODE 0x1E200A6D → rsp_data=0x1E200A6D.
- Response backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_valid and rsp_data stable, cmd_ready=0, busy=1, TCK=0 throughout; busy falls one cycle after handshake.
- Shift DR len=16; assert rst for one cycle at the 10th TCK rise → next clk TCK=0, TMS=1, busy=0, rsp_valid=0; no response ever issued; cmd_ready=1 one cycle later.
- Idle command len=0 → no TCK edges, rsp_valid=1 within 2 cycles of accept. Idle command len=3 → exactly 3 TCK rises with TMS=0.
